// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Instruction fetches are always a 4-byte read.
    localparam logic [2:0] FETCH_SIZE = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one split-transaction memory port between instruction fetch and
// data requests. One transaction is in flight at a time. Data wins ties,
// except when it has already taken MAX_D_STREAK grants in a row while a
// fetch was waiting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [63:0] i_addr,
    output logic        i_ok,
    output logic [31:0] i_data,
    input  logic        d_valid,
    input  logic [63:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [7:0]  d_strobe,
    input  logic [63:0] d_wdata,
    output logic        d_ok,
    output logic [63:0] d_rdata,
    output logic        m_valid,
    output logic [63:0] m_addr,
    output logic [2:0]  m_size,
    output logic [7:0]  m_strobe,
    output logic [63:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [63:0] m_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    arb_state_t state_q, state_d;
    owner_t     owner_q, owner_d;
    logic [3:0] d_streak_q, d_streak_d;
    logic       done;

    // Next state, owner selection in IDLE and fetch-starvation streak tracking.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        d_streak_d = d_streak_q;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_valid || i_valid) begin
                    state_d = REQ;
                    if (d_valid && !(i_valid && d_streak_q == STREAK_MAX)) begin
                        owner_d = OWN_D;
                        // Streak only counts grants that made a fetch wait.
                        if (i_valid) begin
                            d_streak_d = (d_streak_q == STREAK_MAX) ? STREAK_MAX
                                                                    : d_streak_q + 4'd1;
                        end
                    end else begin
                        owner_d    = OWN_I;
                        d_streak_d = 4'd0;
                    end
                end
            end
            REQ: begin
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (m_data_ok) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, owner and streak registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_D;
            d_streak_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            d_streak_q <= d_streak_d;
        end
    end

    // Memory-side request mux and completion/read-data return; reset
    // silences everything in the same cycle so no stray ok escapes.
    always_comb begin
        logic busy;
        logic fin;
        busy     = (state_q == REQ || state_q == WAIT) && !reset;
        fin      = done && !reset;
        m_valid  = (state_q == REQ) && !reset;
        m_addr   = 64'd0;
        m_size   = 3'd0;
        m_strobe = 8'd0;
        m_wdata  = 64'd0;
        if (busy) begin
            if (owner_q == OWN_D) begin
                m_addr   = d_addr;
                m_size   = d_size;
                m_strobe = d_strobe;
                m_wdata  = d_wdata;
            end else begin
                m_addr   = i_addr;
                m_size   = FETCH_SIZE;
            end
        end
        i_ok    = fin && (owner_q == OWN_I);
        d_ok    = fin && (owner_q == OWN_D);
        i_data  = 32'd0;
        d_rdata = 64'd0;
        if (i_ok) begin
            i_data = i_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
        end
        if (d_ok) begin
            d_rdata = m_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (instantiated with MAX_D_STREAK=2).
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_addr;
    logic        i_ok;
    logic [31:0] i_data;
    logic        d_valid;
    logic [63:0] d_addr;
    logic [2:0]  d_size;
    logic [7:0]  d_strobe;
    logic [63:0] d_wdata;
    logic        d_ok;
    logic [63:0] d_rdata;
    logic        m_valid;
    logic [63:0] m_addr;
    logic [2:0]  m_size;
    logic [7:0]  m_strobe;
    logic [63:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [63:0] m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_D_STREAK(2)) dut (
        .clk(clk), .reset(reset),
        .i_valid(i_valid), .i_addr(i_addr), .i_ok(i_ok), .i_data(i_data),
        .d_valid(d_valid), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe),
        .d_wdata(d_wdata), .d_ok(d_ok), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_size(m_size), .m_strobe(m_strobe),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        reset = 1'b1; i_valid = 1'b0; d_valid = 1'b0;
        i_addr = 64'd0; d_addr = 64'd0; d_size = 3'd0; d_strobe = 8'd0; d_wdata = 64'd0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 64'd0;
        tick(); tick();
        #1;
        outs = m_addr | m_wdata | d_rdata | {32'd0, i_data} |
               {42'd0, i_ok, d_ok, m_valid, m_size, m_strobe, 8'd0};
        checks++;
        if (outs !== 64'd0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", outs);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.owner_q !== OWN_D) begin
            errors++; $display("FAIL reset_state got state=%0d owner=%0d want 0/1", dut.state_q, dut.owner_q);
        end
        checks++;
        if (dut.d_streak_q !== 4'd0) begin
            errors++; $display("FAIL reset_streak got %0d want 0", dut.d_streak_q);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_lone_fetch();
        i_valid = 1'b1; i_addr = 64'h8000_0004;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_size !== 3'd2 || m_strobe !== 8'd0 || m_addr !== 64'h8000_0004) begin
            errors++; $display("FAIL fetch_req got v=%b sz=%0d st=%h a=%h want 1/2/00/80000004", m_valid, m_size, m_strobe, m_addr);
        end
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 64'h1111_2222_3333_4444;
        #1;
        checks++;
        if (i_ok !== 1'b1 || i_data !== 32'h1111_2222 || d_ok !== 1'b0) begin
            errors++; $display("FAIL fetch_ok got i_ok=%b data=%h d_ok=%b want 1/11112222/0", i_ok, i_data, d_ok);
        end
        tick();
        i_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        #1;
        checks++;
        if (i_ok !== 1'b0 || m_valid !== 1'b0 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL fetch_done got i_ok=%b m_valid=%b state=%0d want 0/0/0", i_ok, m_valid, dut.state_q);
        end
    endtask

    task automatic test_store_waits();
        int vcnt = 0;
        int okcnt = 0;
        int iokcnt = 0;
        d_valid = 1'b1; d_addr = 64'h8000_1000; d_size = 3'd3; d_strobe = 8'hFF; d_wdata = 64'hDEAD;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 7) d_valid = 1'b0;
            m_addr_ok = (c == 3);
            m_data_ok = (c == 6);
            #1;
            vcnt += int'(m_valid);
            okcnt += int'(d_ok);
            iokcnt += int'(i_ok);
            if (c == 4) begin
                checks++;
                if (dut.state_q !== WAIT || m_addr !== 64'h8000_1000 || m_size !== 3'd3 ||
                    m_strobe !== 8'hFF || m_wdata !== 64'hDEAD) begin
                    errors++; $display("FAIL store_wait got st=%0d a=%h sz=%0d s=%h w=%h want 2/80001000/3/ff/dead",
                                       dut.state_q, m_addr, m_size, m_strobe, m_wdata);
                end
            end
            if (c == 6) begin
                checks++;
                if (d_ok !== 1'b1) begin
                    errors++; $display("FAIL store_ok_cycle got %b want 1", d_ok);
                end
            end
        end
        checks++;
        if (vcnt != 3) begin
            errors++; $display("FAIL store_mvalid_cycles got %0d want 3", vcnt);
        end
        checks++;
        if (okcnt != 1 || iokcnt != 0) begin
            errors++; $display("FAIL store_ok_pulses got d=%0d i=%0d want 1/0", okcnt, iokcnt);
        end
    endtask

    task automatic test_back_to_back();
        owner_t      exp_own [6] = '{OWN_D, OWN_D, OWN_I, OWN_D, OWN_D, OWN_I};
        logic [3:0]  exp_stk [6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
        logic [63:0] exp_addr;
        i_valid = 1'b1; i_addr = 64'h0000_0100;
        d_valid = 1'b1; d_addr = 64'h0000_0200; d_size = 3'd2; d_strobe = 8'h00;
        m_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int g = 0; g < 6; g++) begin
            tick();
            exp_addr = (exp_own[g] == OWN_D) ? 64'h200 : 64'h100;
            checks++;
            if (dut.state_q !== REQ || dut.owner_q !== exp_own[g] ||
                dut.d_streak_q !== exp_stk[g] || m_addr !== exp_addr) begin
                errors++; $display("FAIL grant%0d got st=%0d own=%0d stk=%0d a=%h want 1/%0d/%0d/%h",
                                   g, dut.state_q, dut.owner_q, dut.d_streak_q, m_addr,
                                   exp_own[g], exp_stk[g], exp_addr);
            end
            m_addr_ok = 1'b1; m_data_ok = 1'b1;
            #1;
            checks++;
            if (d_ok !== (exp_own[g] == OWN_D) || i_ok !== (exp_own[g] == OWN_I)) begin
                errors++; $display("FAIL grant%0d_ok got d=%b i=%b want own=%0d", g, d_ok, i_ok, exp_own[g]);
            end
            tick();
            m_addr_ok = 1'b0; m_data_ok = 1'b0;
            checks++;
            if (dut.state_q !== IDLE || m_valid !== 1'b0) begin
                errors++; $display("FAIL grant%0d_bubble got st=%0d mv=%b want 0/0", g, dut.state_q, m_valid);
            end
        end
        i_valid = 1'b0; d_valid = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle_load();
        d_valid = 1'b1; d_addr = 64'h40; d_size = 3'd3; d_strobe = 8'h00; d_wdata = 64'h0;
        tick();
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++;
        if (d_ok !== 1'b1 || d_rdata !== 64'h0123_4567_89AB_CDEF || i_ok !== 1'b0) begin
            errors++; $display("FAIL load_ok got d_ok=%b rd=%h i_ok=%b want 1/0123456789abcdef/0", d_ok, d_rdata, i_ok);
        end
        tick();
        d_valid = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
        checks++;
        if (dut.state_q !== IDLE) begin
            errors++; $display("FAIL load_direct_idle got %0d want 0", dut.state_q);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        i_valid = 1'b1; i_addr = 64'h0000_0300;
        d_valid = 1'b1; d_addr = 64'h0000_0400;
        tick();
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        checks++;
        if (dut.state_q !== WAIT || dut.owner_q !== OWN_D || dut.d_streak_q !== 4'd1) begin
            errors++; $display("FAIL rst_pre got st=%0d own=%0d stk=%0d want 2/1/1", dut.state_q, dut.owner_q, dut.d_streak_q);
        end
        reset = 1'b1; m_data_ok = 1'b1;
        #1;
        checks++;
        if (d_ok !== 1'b0 || i_ok !== 1'b0) begin
            errors++; $display("FAIL rst_no_ok got d=%b i=%b want 0/0", d_ok, i_ok);
        end
        tick();
        reset = 1'b0; m_data_ok = 1'b0; i_valid = 1'b0; d_valid = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== IDLE || dut.d_streak_q !== 4'd0 || m_valid !== 1'b0 ||
            m_addr !== 64'd0 || d_ok !== 1'b0 || i_ok !== 1'b0) begin
            errors++; $display("FAIL rst_after got st=%0d stk=%0d mv=%b a=%h want 0/0/0/0",
                               dut.state_q, dut.d_streak_q, m_valid, m_addr);
        end
        tick();
    endtask

    task automatic test_dropped_valid();
        int extra = 0;
        d_valid = 1'b1; d_addr = 64'h0000_0500; d_size = 3'd3;
        tick();
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0; d_valid = 1'b0;
        tick();
        m_data_ok = 1'b1;
        #1;
        checks++;
        if (d_ok !== 1'b1) begin
            errors++; $display("FAIL drop_ok got %b want 1", d_ok);
        end
        tick();
        m_data_ok = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            extra += int'(m_valid) + int'(d_ok);
            tick();
        end
        checks++;
        if (extra != 0) begin
            errors++; $display("FAIL drop_quiet got %0d activity cycles want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_store_waits();
        test_back_to_back();
        test_same_cycle_load();
        test_reset_mid_wait();
        test_dropped_valid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
